// File: rtl/factorial_batch_dispatcher_pkg.sv
// Shared types and defaults for the factorial batch dispatcher.
// FSM state encoding and result FIFO entry sizing.
package factorial_batch_dispatcher_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPT,
    S_DONE
  } state_t;

  localparam int WIDTH_DEF     = 32;
  localparam int CNT_W_DEF     = 8;
  localparam int DEPTH_DEF     = 4;
  localparam int OVF_LIMIT_DEF = 13;

  // Each FIFO entry carries the overflow tag above the result bits.
  function automatic int entry_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/fact_result_fifo.sv
// Synchronous result FIFO with extra-bit pointers.
// Simultaneous push/pop both take effect; pop on empty is ignored.
module fact_result_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rptr <= rptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/factorial_batch_dispatcher.sv
// Issues a batch of factorial jobs one at a time to the engine
// and collects tagged results into a FIFO drained by MMIO.
module factorial_batch_dispatcher
  import factorial_batch_dispatcher_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int OVF_LIMIT = OVF_LIMIT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_base,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             eng_in_valid,
  input  logic             eng_in_ready,
  output logic [WIDTH-1:0] eng_x,
  input  logic             eng_out_valid,
  output logic             eng_out_ready,
  input  logic [WIDTH-1:0] eng_factorial,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             busy,
  output logic             done
);

  localparam int EW = entry_w(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] OVF_X = WIDTH'(OVF_LIMIT);

  state_t           state;
  logic [WIDTH-1:0] cur_x;
  logic [CNT_W-1:0] remaining;
  logic             ovf_pend;

  logic [EW-1:0]    fifo_head;
  logic [AW:0]      fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;

  assign cmd_ready     = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign eng_out_ready = (state == S_WAIT);
  assign eng_x         = cur_x;
  assign push          = (state == S_CAPT);

  // A free slot at issue time is the reservation for this job's result.
  assign eng_in_valid  = (state == S_ISSUE) & ~fifo_full;

  assign res_valid = (fifo_count != '0);
  assign {res_ovf, res_data} = fifo_empty ? '0 : fifo_head;

  fact_result_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({ovf_pend, eng_factorial}),
    .pop       (res_ready),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_x     <= '0;
      remaining <= '0;
      ovf_pend  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cur_x     <= cmd_base;
            remaining <= cmd_count;
            state     <= (cmd_count == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (eng_in_valid && eng_in_ready) begin
            ovf_pend <= (cur_x >= OVF_X);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (eng_out_valid) begin
            state <= S_CAPT;
          end
        end
        S_CAPT: begin
          cur_x     <= cur_x + WIDTH'(1);
          remaining <= remaining - CNT_W'(1);
          state     <= (remaining == CNT_W'(1)) ? S_DONE : S_ISSUE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_batch_dispatcher.sv
// Bench for factorial_batch_dispatcher: behavioural engine, result model,
// table-driven batches, hand sequences and randomized batches.
module tb_factorial_batch_dispatcher;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_base = '0;
  logic [7:0]  cmd_count = '0;
  logic        eng_in_valid;
  logic        eng_in_ready;
  logic [31:0] eng_x;
  logic        eng_out_valid;
  logic        eng_out_ready;
  logic [31:0] eng_factorial;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_ovf;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  factorial_batch_dispatcher dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_base      (cmd_base),
    .cmd_count     (cmd_count),
    .eng_in_valid  (eng_in_valid),
    .eng_in_ready  (eng_in_ready),
    .eng_x         (eng_x),
    .eng_out_valid (eng_out_valid),
    .eng_out_ready (eng_out_ready),
    .eng_factorial (eng_factorial),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_ovf       (res_ovf),
    .busy          (busy),
    .done          (done)
  );

  // x! mod 2^32; for x >= 34 the product holds at least 32 factors of two.
  function automatic logic [31:0] fact(input logic [31:0] x);
    logic [31:0] r;
    r = 32'd1;
    if (x >= 32'd34) return 32'd0;
    for (int i = 2; i <= int'(x); i++) r = r * 32'(i);
    return r;
  endfunction

  // Engine: one job at a time, programmable compute delay,
  // result presented the cycle after the output handshake.
  int          eng_delay = 1;
  int          e_cnt;
  logic [31:0] e_x;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      eng_in_ready  <= 1'b1;
      eng_out_valid <= 1'b0;
      eng_factorial <= '0;
      e_cnt         <= 0;
      e_x           <= '0;
    end else begin
      if (eng_in_valid && eng_in_ready) begin
        e_x          <= eng_x;
        eng_in_ready <= 1'b0;
        e_cnt        <= eng_delay;
      end else if (!eng_in_ready && !eng_out_valid) begin
        if (e_cnt == 0) eng_out_valid <= 1'b1;
        else e_cnt <= e_cnt - 1;
      end
      if (eng_out_valid && eng_out_ready) begin
        eng_out_valid <= 1'b0;
        eng_factorial <= fact(e_x);
        eng_in_ready  <= 1'b1;
      end
    end
  end

  typedef struct packed {
    logic        ovf;
    logic [31:0] data;
  } res_t;

  res_t expq[$];
  res_t obs[$];
  int   in_hs = 0;
  int   out_hs = 0;
  int   done_cnt = 0;

  always @(negedge clock) begin
    res_t got;
    res_t ex;
    if (!reset) begin
      if (eng_in_valid && eng_in_ready) in_hs++;
      if (eng_out_valid && eng_out_ready) out_hs++;
      if (done) begin
        done_cnt++;
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_at_done got=%0b required=1", busy);
        end
      end
      if (res_valid && res_ready) begin
        got = '{ovf: res_ovf, data: res_data};
        obs.push_back(got);
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL res_unexpected got=%0d ovf=%0b required=none",
                   res_data, res_ovf);
        end else begin
          ex = expq.pop_front();
          if (got !== ex) begin
            errors++;
            $display("FAIL res_value got=%0d ovf=%0b required=%0d ovf=%0b",
                     got.data, got.ovf, ex.data, ex.ovf);
          end
        end
      end
    end
  end

  bit rnd_rdy = 1'b0;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", n, got, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (rnd_rdy) res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] b, input logic [7:0] c);
    bit ok;
    logic [31:0] x;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_base  = b;
    cmd_count = c;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clock);
      if (cmd_ready) begin
        ok = 1'b1;
        for (int i = 0; i < int'(c); i++) begin
          x = b + 32'(i);
          expq.push_back('{ovf: (x >= 32'd13), data: fact(x)});
        end
      end
      step();
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      step();
      k++;
    end
    chk("done_seen", 32'(done_cnt > d0), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((expq.size() != 0 || res_valid) && k < budget) begin
      step();
      k++;
    end
    chk("drain_left", 32'(expq.size()), 32'd0);
  endtask

  typedef struct {
    logic [31:0] base;
    logic [7:0]  count;
    logic [31:0] first;
    logic        first_ovf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int d0;
    int i0;
    int o0;
    logic [31:0] b;
    logic [7:0]  c;

    tbl[0] = '{32'd5,          8'd3, 32'd120,        1'b0};
    tbl[1] = '{32'd12,         8'd2, 32'd479001600,  1'b0};
    tbl[2] = '{32'd13,         8'd1, 32'd1932053504, 1'b1};
    tbl[3] = '{32'd0,          8'd2, 32'd1,          1'b0};
    tbl[4] = '{32'd20,         8'd1, 32'd2192834560, 1'b1};
    tbl[5] = '{32'hFFFF_FFFF,  8'd2, 32'd0,          1'b1};

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_eng_in_valid", 32'(eng_in_valid), 32'd0);
    chk("rst_eng_out_ready", 32'(eng_out_ready), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_ovf", 32'(res_ovf), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    res_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      obs.delete();
      d0 = done_cnt;
      send(tbl[t].base, tbl[t].count);
      wait_done(200);
      repeat (3) step();
      wait_drain(100);
      chk("tbl_count", 32'(obs.size()), 32'(tbl[t].count));
      if (obs.size() > 0) begin
        chk("tbl_first", obs[0].data, tbl[t].first);
        chk("tbl_first_ovf", 32'(obs[0].ovf), 32'(tbl[t].first_ovf));
      end
      chk("tbl_done_pulses", 32'(done_cnt - d0), 32'd1);
    end

    i0 = in_hs;
    d0 = done_cnt;
    send(32'd7, 8'd0);
    repeat (4) step();
    chk("zero_no_issue", 32'(in_hs - i0), 32'd0);
    chk("zero_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("zero_idle_after", 32'(busy), 32'd0);

    res_ready = 1'b0;
    eng_delay = 0;
    obs.delete();
    i0 = in_hs;
    send(32'd1, 8'd6);
    repeat (40) step();
    @(negedge clock);
    chk("stall_issued", 32'(in_hs - i0), 32'd4);
    chk("stall_in_valid", 32'(eng_in_valid), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_res_valid", 32'(res_valid), 32'd1);
    step();
    res_ready = 1'b1;
    wait_done(200);
    wait_drain(100);
    chk("stall_total_issued", 32'(in_hs - i0), 32'd6);
    chk("stall_obs", 32'(obs.size()), 32'd6);
    if (obs.size() == 6) begin
      chk("stall_fifth", obs[4].data, 32'd120);
      chk("stall_sixth", obs[5].data, 32'd720);
    end

    res_ready = 1'b0;
    eng_delay = 2;
    obs.delete();
    o0 = out_hs;
    send(32'd2, 8'd5);
    for (int k = 0; k < 300 && (out_hs - o0) < 4; k++) step();
    chk("pp_reach_fourth", 32'(out_hs - o0), 32'd4);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_base  = 32'd100;
    cmd_count = 8'd1;
    @(negedge clock);
    chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    cmd_valid = 1'b0;
    wait_done(300);
    repeat (3) step();
    chk("pp_popped", 32'(obs.size()), 32'd1);
    chk("pp_res_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    wait_drain(100);
    chk("pp_total", 32'(obs.size()), 32'd5);

    res_ready = 1'b0;
    eng_delay = 3;
    i0 = in_hs;
    send(32'd10, 8'd4);
    for (int k = 0; k < 100 && in_hs == i0; k++) step();
    chk("rst_mid_issued", 32'(in_hs - i0), 32'd1);
    reset = 1'b1;
    expq.delete();
    @(negedge clock);
    chk("rst_mid_res_valid", 32'(res_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clock);
    #1 reset = 1'b0;
    res_ready = 1'b1;
    obs.delete();
    send(32'd3, 8'd1);
    wait_done(200);
    wait_drain(100);
    chk("post_rst_obs", 32'(obs.size()), 32'd1);
    if (obs.size() == 1) chk("post_rst_value", obs[0].data, 32'd6);

    for (int r = 0; r < 10; r++) begin
      eng_delay = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 20));
      else b = $urandom;
      c = 8'($urandom_range(0, 7));
      d0 = done_cnt;
      rnd_rdy = 1'b1;
      send(b, c);
      wait_done(400);
      rnd_rdy = 1'b0;
      res_ready = 1'b1;
      wait_drain(200);
      chk("rnd_done_pulses", 32'(done_cnt - d0), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
